// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - fetch-to-decode instruction FIFO; IQ_BYPASS_EN adds an empty-queue bypass
// Holds {pc, instr} pairs between fetch and decode, dropped wholesale on a pipeline flush.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic [31:0]      fetch_instr,
  output logic             fetch_ready,
  output logic             dec_valid,
  output logic [31:0]      dec_pc,
  output logic [31:0]      dec_instr,
  input  logic             dec_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [63:0]      mem_q [DEPTH];
  logic [63:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;
  logic bypass_hit;

  assign fetch_ready = (count_q != FULL_CNT) | dec_ready;
  assign count       = count_q;
  assign push        = fetch_valid & fetch_ready;
  assign pop         = dec_valid & dec_ready;

`ifdef IQ_BYPASS_EN
  // An empty queue hands the fetch entry straight to decode; it is only stored if decode stalls.
  assign bypass_hit = (count_q == '0) & fetch_valid & ~flush;
`else
  assign bypass_hit = 1'b0;
`endif

  assign wr_en = push & ~(bypass_hit & dec_ready);
  assign rd_en = pop & ~bypass_hit;

  always_comb begin
    dec_valid = (count_q != '0);
    dec_pc    = mem_q[head_q][63:32];
    dec_instr = mem_q[head_q][31:0];
    if (bypass_hit) begin
      dec_valid = 1'b1;
      dec_pc    = fetch_pc;
      dec_instr = fetch_instr;
    end
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[tail_q] = {fetch_pc, fetch_instr};
        tail_d        = tail_q + PTR_ONE;
      end
      if (rd_en) begin
        head_d = head_q + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - directed self-checking bench for instr_queue (DEPTH=8)
module tb_instr_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_ready;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_ready;
  logic [3:0]  count;

  int n_tests;
  int n_fail;

  instr_queue #(.DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .fetch_ready (fetch_ready),
    .dec_valid   (dec_valid),
    .dec_pc      (dec_pc),
    .dec_instr   (dec_instr),
    .dec_ready   (dec_ready),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic test_reset();
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid got %0b exp 0", dec_valid); end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_ready got %0b exp 1", fetch_ready); end
    n_tests++; if (dec_pc !== 32'h0) begin n_fail++; $display("FAIL reset_dec_pc got %h exp 0", dec_pc); end
    n_tests++; if (dec_instr !== 32'h0) begin n_fail++; $display("FAIL reset_dec_instr got %h exp 0", dec_instr); end
  endtask

  task automatic test_single();
    fetch_valid = 1'b1; fetch_pc = 32'h1000; fetch_instr = 32'h0050_0093; dec_ready = 1'b0;
    #1;
`ifndef IQ_BYPASS_EN
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency got %0b exp 0", dec_valid); end
`endif
    tick();
    fetch_valid = 1'b0;
    #1;
    n_tests++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL single_dec_valid got %0b exp 1", dec_valid); end
    n_tests++; if (dec_pc !== 32'h1000) begin n_fail++; $display("FAIL single_dec_pc got %h exp 00001000", dec_pc); end
    n_tests++; if (dec_instr !== 32'h0050_0093) begin n_fail++; $display("FAIL single_dec_instr got %h exp 00500093", dec_instr); end
    n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", count); end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    #1;
    n_tests++; if (count !== 4'd0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain count %0d valid %0b exp 0 0", count, dec_valid); end
  endtask

  task automatic test_fill();
    dec_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fetch_valid = 1'b1; fetch_pc = 32'h1000 + 32'(4 * i); fetch_instr = instr_of(fetch_pc);
      tick();
    end
    fetch_pc = 32'h1020; fetch_instr = instr_of(32'h1020);
    #1;
    n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count got %0d exp 8", count); end
    n_tests++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fill_fetch_ready got %0b exp 0", fetch_ready); end
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (count !== 4'd8 || dec_pc !== 32'h1000) begin n_fail++; $display("FAIL fill_hold count %0d pc %h exp 8 00001000", count, dec_pc); end
    dec_ready = 1'b1;
    #1;
    n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_on_pop got %0b exp 1", fetch_ready); end
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h1000 + 32'(4 * i) || dec_instr !== instr_of(32'h1000 + 32'(4 * i))) begin
        n_fail++; $display("FAIL fill_order[%0d] valid %0b pc %h instr %h exp pc %h", i, dec_valid, dec_pc, dec_instr, 32'h1000 + 32'(4 * i));
      end
      tick();
      fetch_valid = 1'b0;
      if (i == 0) begin
        n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_full_pushpop count %0d exp 8", count); end
      end
    end
    dec_ready = 1'b0;
    #1;
    n_tests++; if (count !== 4'd0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL fill_drained count %0d valid %0b exp 0 0", count, dec_valid); end
  endtask

  task automatic test_back_to_back();
    dec_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fetch_valid = 1'b1; fetch_pc = 32'h3000 + 32'(4 * i); fetch_instr = instr_of(fetch_pc);
      tick();
    end
    dec_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      fetch_valid = 1'b1; fetch_pc = 32'h3020 + 32'(4 * k); fetch_instr = instr_of(fetch_pc);
      #1;
      n_tests++;
      if (fetch_ready !== 1'b1 || count !== 4'd8 || dec_pc !== 32'h3000 + 32'(4 * k)) begin
        n_fail++; $display("FAIL b2b[%0d] ready %0b count %0d pc %h exp 1 8 %h", k, fetch_ready, count, dec_pc, 32'h3000 + 32'(4 * k));
      end
      tick();
    end
    fetch_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #1;
      n_tests++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h3050 + 32'(4 * j)) begin
        n_fail++; $display("FAIL b2b_drain[%0d] valid %0b pc %h exp %h", j, dec_valid, dec_pc, 32'h3050 + 32'(4 * j));
      end
      tick();
    end
    dec_ready = 1'b0;
    #1;
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL b2b_empty count %0d exp 0", count); end
  endtask

  task automatic test_flush();
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch_valid = 1'b1; fetch_pc = 32'h4000 + 32'(4 * i); fetch_instr = instr_of(fetch_pc);
      tick();
    end
    n_tests++; if (count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count got %0d exp 5", count); end
    flush = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h4FF0; fetch_instr = instr_of(32'h4FF0); dec_ready = 1'b1;
    #1;
    n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL flush_fetch_ready got %0b exp 1", fetch_ready); end
    tick();
    flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
    #1;
    n_tests++; if (count !== 4'd0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear count %0d valid %0b exp 0 0", count, dec_valid); end
    fetch_valid = 1'b1; fetch_pc = 32'h5000; fetch_instr = instr_of(32'h5000);
    tick();
    fetch_valid = 1'b0;
    #1;
    n_tests++; if (count !== 4'd1 || dec_pc !== 32'h5000) begin n_fail++; $display("FAIL flush_after count %0d pc %h exp 1 00005000", count, dec_pc); end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    #1;
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped_entry valid %0b pc %h exp empty", dec_valid, dec_pc); end
  endtask

  task automatic test_async_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1'b1; fetch_pc = 32'h6000 + 32'(4 * i); fetch_instr = instr_of(fetch_pc);
      tick();
    end
    fetch_valid = 1'b0;
    n_tests++; if (count !== 4'd3) begin n_fail++; $display("FAIL areset_pre_count got %0d exp 3", count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL areset_dec_valid got %0b exp 0", dec_valid); end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL areset_count got %0d exp 0", count); end
    n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL areset_fetch_ready got %0b exp 1", fetch_ready); end
    n_tests++; if (dec_pc !== 32'h0) begin n_fail++; $display("FAIL areset_dec_pc got %h exp 0", dec_pc); end
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    n_tests++; if (count !== 4'd0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL areset_release count %0d valid %0b exp 0 0", count, dec_valid); end
  endtask

`ifdef IQ_BYPASS_EN
  task automatic test_bypass();
    fetch_valid = 1'b1; fetch_pc = 32'h2000; fetch_instr = 32'h0000_0011; dec_ready = 1'b1;
    #1;
    n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'h2000 || dec_instr !== 32'h11) begin n_fail++; $display("FAIL bypass_same_cycle valid %0b pc %h instr %h exp 1 00002000 00000011", dec_valid, dec_pc, dec_instr); end
    tick();
    fetch_valid = 1'b0; dec_ready = 1'b0;
    #1;
    n_tests++; if (count !== 4'd0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_consumed count %0d valid %0b exp 0 0", count, dec_valid); end
    fetch_valid = 1'b1; fetch_pc = 32'h2004; fetch_instr = 32'h0000_0022;
    tick();
    fetch_valid = 1'b0;
    #1;
    n_tests++; if (count !== 4'd1 || dec_pc !== 32'h2004) begin n_fail++; $display("FAIL bypass_stall_write count %0d pc %h exp 1 00002004", count, dec_pc); end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask
`endif

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0; dec_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef IQ_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- FIFO between the fetch stage and the decode control ROM.
- Buffers fetched {pc, instr} pairs so fetch and decode stall independently.
- Presents the oldest entry to decode with a valid/ready handshake.
- Dropped entirely on a pipeline flush (branch/jump redirect from the ROB).

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  redirect; discard all entries.
- fetch_valid  input  1  fetch offers an entry.
- fetch_pc  input  32  PC of offered instruction.
- fetch_instr  input  32  raw instruction word.
- fetch_ready  output  1  queue accepts this cycle.
- dec_valid  output  1  head entry valid to decode.
- dec_pc  output  32  PC of head entry.
- dec_instr  output  32  instruction word of head entry.
- dec_ready  input  1  decode consumes head this cycle.
- count  output  PTR_W+1  number of occupied entries.

Behaviour:
- Storage: DEPTH x 64-bit array {pc, instr}, plus head/tail pointers (PTR_W bits, wrap modulo DEPTH) and an occupancy counter (PTR_W+1 bits).
- Reset (async, rst_n=0):
  - head=0, tail=0, count=0; storage cleared to 0.
  - Outputs: dec_valid=0, dec_pc=0, dec_instr=0, fetch_ready=1.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- push = fetch_valid & fetch_ready. pop = dec_valid & dec_ready.
- fetch_ready = (count != DEPTH) | dec_ready, i.e. a full queue accepts when decode pops the same cycle.
- dec_valid = (count != 0). dec_pc/dec_instr = storage[head], driven combinationally from registered state.
- Push: write storage[tail], tail+1 at the edge. Pop: head+1 at the edge.
- count next value:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on push & pop (including at full and with count==1).
- Latency: an entry pushed in cycle N is visible on dec_* in cycle N+1 (bypass disabled).
- Ordering: strict FIFO; pointers wrap from DEPTH-1 to 0 with no bubble.
- Flush:
  - Priority over push and pop in the same cycle.
  - Next cycle: head=tail=0, count=0, dec_valid=0.
  - The entry offered by fetch in the flush cycle is dropped; fetch_ready still follows the rule above.
- Empty & pop attempt: impossible, since dec_valid=0. Full & push without pop: fetch_ready=0, and fetch must hold its inputs stable.
- Outputs from the register state (dec_*, count) have no combinational path from fetch_* inputs.
  - fetch_ready has a combinational path from dec_ready.
  - The bypass feature adds paths from fetch_* (see below).

Optional Feature:
- Macro IQ_BYPASS_EN.
- Defined: when count==0 and fetch_valid=1 and flush=0:
  - dec_valid=1 combinationally, with dec_pc/dec_instr = fetch_pc/fetch_instr the same cycle.
  - If dec_ready=1, the entry is consumed and not written; count stays 0.
  - If dec_ready=0, it is written normally.
- Not defined: bypass path absent; minimum latency is 1 cycle; dec_* depend only on registered state.

Test Plan:
- Reset, then push pc=0x1000 instr=0x00500093 with dec_ready=0 -> next cycle dec_valid=1, dec_pc=0x1000, dec_instr=0x00500093, count=1.
- Push 8 entries pc=0x1000..0x101C with dec_ready=0 (DEPTH=8) -> count=8, fetch_ready=0; a 9th offer is held without loss; raise dec_ready -> pops return pc 0x1000,0x1004,...,0x101C in order.
- Full queue, fetch_valid=1, dec_ready=1 for 20 cycles -> count stays 8, output PCs strictly sequential across pointer wrap, no bubble.
- count=5, assert flush together with push and pop -> next cycle count=0, dec_valid=0; the flushed-cycle push does not appear later.
- Drop rst_n asynchronously mid-cycle with count=3 -> dec_valid falls before the next clk edge; count=0, fetch_ready=1.
- IQ_BYPASS_EN defined, empty queue, fetch_valid=1 pc=0x2000, dec_ready=1 -> dec_valid=1 and dec_pc=0x2000 in the same cycle, count remains 0.
